// File: rtl/ex_pkg.sv
// Shared encodings, bus widths and reset/zero constants for the execute stage.
// Imported by ex and div.
package ex_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam int   AluOpBus   = 8;
  localparam int   AluSelBus  = 3;
  localparam int   RegAddrBus = 5;

  localparam logic [31:0]           ZeroWord   = 32'h0000_0000;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

  localparam logic [AluOpBus-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [AluOpBus-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [AluOpBus-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [AluOpBus-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [AluOpBus-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [AluOpBus-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [AluOpBus-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [AluOpBus-1:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [AluOpBus-1:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [AluOpBus-1:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [AluOpBus-1:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [AluOpBus-1:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [AluOpBus-1:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [AluOpBus-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [AluOpBus-1:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [AluSelBus-1:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [AluSelBus-1:0] EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div.sv
// Iterative restoring divider: 32 steps, 34 cycles start to result (divide-by-zero: 2).
// stall is high from start until the result cycle; operands are sampled only when idle.
module div
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        stall,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  div_state_t  state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic        neg_q, neg_r;

  logic        op1_neg, op2_neg;
  logic [31:0] op1_abs, op2_abs;
  logic [32:0] trial, diff;
  logic        fits;

  assign op1_neg = signed_div & op1[31];
  assign op2_neg = signed_div & op2[31];
  assign op1_abs = op1_neg ? (32'd0 - op1) : op1;
  assign op2_abs = op2_neg ? (32'd0 - op2) : op2;

  // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
  assign trial = {rem_q, quo_q[31]};
  assign diff  = trial - {1'b0, dvs_q};
  assign fits  = trial >= {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (rst == RstEnable) state <= DIV_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = (op2 == 32'd0) ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        stall = 1'b1;
        if (cnt == 6'd31) state_nxt = DIV_DONE;
      end
      DIV_DONE: begin
        done      = 1'b1;
        state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt   <= 6'd0;
      quo_q <= 32'd0;
      rem_q <= 32'd0;
      dvs_q <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          cnt <= 6'd0;
          if (start) begin
            if (op2 == 32'd0) begin
              // Divide-by-zero result is loaded directly with no sign fix-up.
              rem_q <= op1;
              quo_q <= 32'hFFFF_FFFF;
              dvs_q <= 32'd0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              rem_q <= 32'd0;
              quo_q <= op1_abs;
              dvs_q <= op2_abs;
              neg_q <= op1_neg ^ op2_neg;
              neg_r <= op1_neg;
            end
          end
        end
        DIV_BUSY: begin
          rem_q <= fits ? diff[31:0] : trial[31:0];
          quo_q <= {quo_q[30:0], fits};
          cnt   <= cnt + 6'd1;
        end
        default: cnt <= 6'd0;
      endcase
    end
  end

  assign quot = neg_q ? (32'd0 - quo_q) : quo_q;
  assign rem  = neg_r ? (32'd0 - rem_q) : rem_q;

endmodule

// File: rtl/ex.sv
// Execute stage: combinational ALU/shift/move result mux plus HI/LO owned here.
// Zero-cycle for ALU ops; DIV/DIVU raise stallreq until the divider's result cycle.
module ex
  import ex_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AluOpBus-1:0]   aluop,
  input  logic [AluSelBus-1:0]  alusel,
  input  logic [31:0]           src1_data,
  input  logic [31:0]           src2_data,
  input  logic [RegAddrBus-1:0] dest_addr,
  input  logic                  wreg,
  output logic [RegAddrBus-1:0] wd,
  output logic                  wreg_o,
  output logic [31:0]           wdata,
  output logic                  stallreq
);

  logic [31:0] hi, lo;
  logic [31:0] logic_res, shift_res, arith_res, move_res;
  logic [31:0] div_quot, div_rem;
  logic        div_stall, div_done;
  logic        is_div;
  logic [4:0]  sa;

  assign is_div = (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
  assign sa     = src1_data[4:0];

  div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .signed_div(aluop == EXE_DIV_OP),
    .op1       (src1_data),
    .op2       (src2_data),
    .stall     (div_stall),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi <= ZeroWord;
      lo <= ZeroWord;
    end else if (div_done) begin
      hi <= div_rem;
      lo <= div_quot;
    end
  end

  always_comb begin
    logic_res = ZeroWord;
    shift_res = ZeroWord;
    arith_res = ZeroWord;
    move_res  = ZeroWord;
    case (aluop)
      EXE_OR_OP:   logic_res = src1_data | src2_data;
      EXE_AND_OP:  logic_res = src1_data & src2_data;
      EXE_XOR_OP:  logic_res = src1_data ^ src2_data;
      EXE_NOR_OP:  logic_res = ~(src1_data | src2_data);
      EXE_SLL_OP:  shift_res = src2_data << sa;
      EXE_SRL_OP:  shift_res = src2_data >> sa;
      EXE_SRA_OP:  shift_res = $signed(src2_data) >>> sa;
      EXE_ADDU_OP: arith_res = src1_data + src2_data;
      EXE_SUBU_OP: arith_res = src1_data - src2_data;
      EXE_SLT_OP:  arith_res = {31'd0, $signed(src1_data) < $signed(src2_data)};
      EXE_SLTU_OP: arith_res = {31'd0, src1_data < src2_data};
      EXE_MFHI_OP: move_res  = hi;
      EXE_MFLO_OP: move_res  = lo;
      default:     ;
    endcase
  end

  always_comb begin
    wd       = NOPRegAddr;
    wreg_o   = 1'b0;
    wdata    = ZeroWord;
    stallreq = 1'b0;
    if (rst != RstEnable) begin
      wd       = dest_addr;
      wreg_o   = is_div ? 1'b0 : wreg;
      stallreq = div_stall;
      case (alusel)
        EXE_RES_LOGIC: wdata = logic_res;
        EXE_RES_SHIFT: wdata = shift_res;
        EXE_RES_ARITH: wdata = arith_res;
        EXE_RES_MOVE:  wdata = move_res;
        EXE_RES_NOP:   wdata = ZeroWord;
        default:       wdata = ZeroWord;
      endcase
    end
  end

endmodule

// File: tb/tb_ex.sv
// Bench for ex: directed vector table, divider corner sequences, randomized ALU/divide vs model.
module tb_ex;
  import ex_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [AluOpBus-1:0]   aluop;
  logic [AluSelBus-1:0]  alusel;
  logic [31:0]           src1_data, src2_data;
  logic [RegAddrBus-1:0] dest_addr;
  logic                  wreg;
  logic [RegAddrBus-1:0] wd;
  logic                  wreg_o;
  logic [31:0]           wdata;
  logic                  stallreq;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  ex dut (
    .clk(clk), .rst(rst), .aluop(aluop), .alusel(alusel),
    .src1_data(src1_data), .src2_data(src2_data),
    .dest_addr(dest_addr), .wreg(wreg),
    .wd(wd), .wreg_o(wreg_o), .wdata(wdata), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic w);
    aluop = op; alusel = sel; src1_data = a; src2_data = b; dest_addr = d; wreg = w;
    #1;
  endtask

  // Reference: plain arithmetic on integers, independent of any bit-level structure.
  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint ua, ub, sa_v, sb_v, p, r;
    ua = a; ub = b; sa_v = $signed(a); sb_v = $signed(b);
    p  = longint'(1) << a[4:0];
    r  = 0;
    case (op)
      EXE_OR_OP:   r = ua | ub;
      EXE_AND_OP:  r = ua & ub;
      EXE_XOR_OP:  r = ua ^ ub;
      EXE_NOR_OP:  r = ~(ua | ub);
      EXE_SLL_OP:  r = ub * p;
      EXE_SRL_OP:  r = ub / p;
      EXE_SRA_OP:  r = (sb_v >= 0) ? sb_v / p : -((-sb_v + p - 1) / p);
      EXE_ADDU_OP: r = ua + ub;
      EXE_SUBU_OP: r = ua - ub;
      EXE_SLT_OP:  r = (sa_v < sb_v) ? 1 : 0;
      EXE_SLTU_OP: r = (ua < ub) ? 1 : 0;
      EXE_MFHI_OP: r = longint'(hi_m);
      EXE_MFLO_OP: r = longint'(lo_m);
      default:     r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
    longint x, y, q, r;
    if (b == 32'd0) begin
      h = a; l = 32'hFFFF_FFFF;
    end else begin
      if (sgn) begin x = $signed(a); y = $signed(b); end
      else     begin x = a;          y = b;          end
      q = x / y; r = x % y;
      l = q[31:0]; h = r[31:0];
    end
  endtask

  // Presents a divide, counts stall cycles, then reads LO and HI back with MFLO/MFHI.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit scramble);
    int n;
    drive(op, EXE_RES_NOP, a, b, 5'd9, 1'b1);
    chk({tag, "_wreg_o"}, {31'd0, wreg_o}, 32'd0);
    n = 0;
    while (stallreq === 1'b1 && n < 200) begin
      n++;
      step();
      if (scramble) drive(op, EXE_RES_NOP, $urandom, $urandom, 5'd9, 1'b1);
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    hi_m = exp_hi; lo_m = exp_lo;
    step();
    drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd4, 1'b1);
    chk({tag, "_lo"}, wdata, exp_lo);
    step();
    drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd4, 1'b1);
    chk({tag, "_hi"}, wdata, exp_hi);
    step();
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        w;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [7:0] op;
    logic [2:0] sel;
  } opsel_t;

  initial begin
    vec_t   vecs[13];
    opsel_t ops[13];
    logic [31:0] eh, el, ra, rb;
    bit sgn;

    vecs[0]  = '{EXE_ADDU_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000};
    vecs[1]  = '{EXE_SRA_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'hF000_0000, 1'b1, 32'hFF00_0000};
    vecs[2]  = '{EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001};
    vecs[3]  = '{EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000};
    vecs[4]  = '{EXE_OR_OP,   EXE_RES_LOGIC, 32'h0F0F_0000, 32'h0000_00FF, 1'b1, 32'h0F0F_00FF};
    vecs[5]  = '{EXE_AND_OP,  EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 32'h00F0_00F0};
    vecs[6]  = '{EXE_XOR_OP,  EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 32'hF0F0_0F0F};
    vecs[7]  = '{EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF};
    vecs[8]  = '{EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_003F, 32'h0000_0001, 1'b1, 32'h8000_0000};
    vecs[9]  = '{EXE_SRL_OP,  EXE_RES_SHIFT, 32'h0000_0008, 32'h8000_0000, 1'b1, 32'h0080_0000};
    vecs[10] = '{EXE_SUBU_OP, EXE_RES_ARITH, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF};
    vecs[11] = '{EXE_ADDU_OP, EXE_RES_ARITH, 32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005};
    vecs[12] = '{EXE_ADDU_OP, EXE_RES_NOP,   32'h1234_5678, 32'h1111_1111, 1'b1, 32'h0000_0000};

    ops = '{'{EXE_OR_OP, EXE_RES_LOGIC}, '{EXE_AND_OP, EXE_RES_LOGIC},
            '{EXE_XOR_OP, EXE_RES_LOGIC}, '{EXE_NOR_OP, EXE_RES_LOGIC},
            '{EXE_SLL_OP, EXE_RES_SHIFT}, '{EXE_SRL_OP, EXE_RES_SHIFT},
            '{EXE_SRA_OP, EXE_RES_SHIFT}, '{EXE_ADDU_OP, EXE_RES_ARITH},
            '{EXE_SUBU_OP, EXE_RES_ARITH}, '{EXE_SLT_OP, EXE_RES_ARITH},
            '{EXE_SLTU_OP, EXE_RES_ARITH}, '{EXE_MFHI_OP, EXE_RES_MOVE},
            '{EXE_MFLO_OP, EXE_RES_MOVE}};

    // Reset: outputs forced to idle values even with a live instruction presented.
    rst = 1'b1;
    drive(EXE_ADDU_OP, EXE_RES_ARITH, 32'd1, 32'd1, 5'd7, 1'b1);
    step(); step();
    chk("rst_wd", {27'd0, wd}, {27'd0, NOPRegAddr});
    chk("rst_wreg_o", {31'd0, wreg_o}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd10, 32'd3, 5'd7, 1'b1);
    chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
    step();
    rst = 1'b0;
    drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
    chk("rst_hi", wdata, 32'd0);
    drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
    chk("rst_lo", wdata, 32'd0);
    step();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, 5'(i + 3), vecs[i].w);
      chk($sformatf("vec%0d_wdata", i), wdata, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_wreg_o", i), {31'd0, wreg_o}, {31'd0, vecs[i].w});
      chk($sformatf("vec%0d_wd", i), {27'd0, wd}, 32'(i + 3));
      chk($sformatf("vec%0d_stall", i), {31'd0, stallreq}, 32'd0);
      step();
    end

    run_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_div("divu_by0", EXE_DIVU_OP, 32'd100, 32'd0, 1, 32'd100, 32'hFFFF_FFFF, 1'b0);
    run_div("div_minneg", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0);
    run_div("div_pos_neg", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b1);

    // Reset arriving in BUSY cycle 10 discards the division and clears HI/LO.
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'd3, 5'd2, 1'b1);
    for (int i = 0; i <= 10; i++) step();
    chk("rstmid_busy_stall", {31'd0, stallreq}, 32'd1);
    rst = 1'b1;
    drive(8'h00, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("rstmid_forced_stall", {31'd0, stallreq}, 32'd0);
    step();
    rst = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
    chk("rstmid_stall", {31'd0, stallreq}, 32'd0);
    chk("rstmid_hi", wdata, 32'd0);
    drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd1, 1'b1);
    chk("rstmid_lo", wdata, 32'd0);
    step();
    run_div("after_rst", EXE_DIVU_OP, 32'd8, 32'd2, 33, 32'd0, 32'd4, 1'b0);

    for (int i = 0; i < 16; i++) begin
      sgn = $urandom_range(0, 1) == 1;
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 300);
        2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 300);
        default: rb = $urandom;
      endcase
      ref_div(sgn, ra, rb, eh, el);
      run_div($sformatf("rdiv%0d", i), sgn ? EXE_DIV_OP : EXE_DIVU_OP, ra, rb,
              (rb == 32'd0) ? 1 : 33, eh, el, 1'b1);
    end

    for (int i = 0; i < 150; i++) begin
      int k;
      logic [4:0] d;
      logic w;
      k  = $urandom_range(0, 12);
      ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 >> $urandom_range(0, 31) : $urandom;
      rb = $urandom;
      d  = 5'($urandom);
      w  = 1'($urandom);
      drive(ops[k].op, ops[k].sel, ra, rb, d, w);
      chk($sformatf("ralu%0d_wdata", i), wdata, ref_alu(ops[k].op, ra, rb));
      chk($sformatf("ralu%0d_wreg_o", i), {31'd0, wreg_o}, {31'd0, w});
      chk($sformatf("ralu%0d_wd", i), {27'd0, wd}, {27'd0, d});
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
